// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: rotates (Xin, Yin) by a 32-bit binary angle,
// one micro-rotation per clock, CORDIC gain K ~= 1.64676 left in the result.
module cordic_rotate #(
    parameter int SZ   = 16,
    parameter int ITER = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SZ-1:0] Xin,
    input  logic [SZ-1:0] Yin,
    input  logic [31:0]   angle,
    output logic [SZ:0]   Xout,
    output logic [SZ:0]   Yout,
    output logic          busy,
    output logic          done
);

    localparam int            IW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [IW-1:0] LAST = IW'(ITER - 1);

    typedef enum logic {IDLE, ROT} state_t;

    // round(atan(2^-i) * 2^32 / 2pi)
    function automatic logic [31:0] atan_lut(input logic [4:0] i);
        logic [31:0] r;
        case (i)
            5'd0:  r = 32'h20000000;
            5'd1:  r = 32'h12E4051E;
            5'd2:  r = 32'h09FB385B;
            5'd3:  r = 32'h051111D4;
            5'd4:  r = 32'h028B0D43;
            5'd5:  r = 32'h0145D7E1;
            5'd6:  r = 32'h00A2F61E;
            5'd7:  r = 32'h00517C55;
            5'd8:  r = 32'h0028BE53;
            5'd9:  r = 32'h00145F2F;
            5'd10: r = 32'h000A2F98;
            5'd11: r = 32'h000517CC;
            5'd12: r = 32'h00028BE6;
            5'd13: r = 32'h000145F3;
            5'd14: r = 32'h0000A2FA;
            5'd15: r = 32'h0000517D;
            5'd16: r = 32'h000028BE;
            5'd17: r = 32'h0000145F;
            5'd18: r = 32'h00000A30;
            5'd19: r = 32'h00000518;
            5'd20: r = 32'h0000028C;
            5'd21: r = 32'h00000146;
            5'd22: r = 32'h000000A3;
            5'd23: r = 32'h00000051;
            5'd24: r = 32'h00000029;
            5'd25: r = 32'h00000014;
            5'd26: r = 32'h0000000A;
            5'd27: r = 32'h00000005;
            5'd28: r = 32'h00000003;
            5'd29: r = 32'h00000001;
            5'd30: r = 32'h00000001;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic signed [SZ:0]   x_q, x_d, y_q, y_d;
    logic [31:0]          z_q, z_d;
    logic [SZ:0]          xout_q, xout_d, yout_q, yout_d;
    logic                 done_q, done_d;

    logic signed [SZ:0]   xin_s, yin_s, x_sh, y_sh, x_n, y_n;
    logic [31:0]          z_n, atan_i;

    always_comb begin
        xin_s  = {Xin[SZ-1], Xin};
        yin_s  = {Yin[SZ-1], Yin};
        x_sh   = x_q >>> iter_q;
        y_sh   = y_q >>> iter_q;
        atan_i = atan_lut(5'(iter_q));

        // Drive z toward zero: positive residual rotates counter-clockwise.
        if (!z_q[31]) begin
            x_n = x_q - y_sh;
            y_n = y_q + x_sh;
            z_n = z_q - atan_i;
        end else begin
            x_n = x_q + y_sh;
            y_n = y_q - x_sh;
            z_n = z_q + atan_i;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xout_d  = xout_q;
        yout_d  = yout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Fold quadrants 1/2 into [-90,+90] so the iterations converge.
                    case (angle[31:30])
                        2'b01: begin
                            x_d = -yin_s;
                            y_d = xin_s;
                            z_d = angle - 32'h40000000;
                        end
                        2'b10: begin
                            x_d = yin_s;
                            y_d = -xin_s;
                            z_d = angle + 32'h40000000;
                        end
                        default: begin
                            x_d = xin_s;
                            y_d = yin_s;
                            z_d = angle;
                        end
                    endcase
                    iter_d  = '0;
                    state_d = ROT;
                end
            end
            ROT: begin
                x_d = x_n;
                y_d = y_n;
                z_d = z_n;
                if (iter_q == LAST) begin
                    xout_d  = x_n;
                    yout_d  = y_n;
                    done_d  = 1'b1;
                    iter_d  = '0;
                    state_d = IDLE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xout_q  <= '0;
            yout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xout_q  <= xout_d;
            yout_q  <= yout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ROT);
    assign done = done_q;
    assign Xout = xout_q;
    assign Yout = yout_q;

endmodule
